// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding and skid depth.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer of {last, data} words; entry 0 is always the head.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  head_vld,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH:0] ent0;
    logic [DATA_WIDTH:0] ent1;
    logic                pop_ok;
    logic                push_ok;
    logic [DATA_WIDTH:0] new_ent;

    assign new_ent = {push_last, push_data};
    assign pop_ok  = pop && (occ != 2'd0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign push_ok = push && ((occ < 2'(SKID_DEPTH)) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (occ == 2'd0) ent0 <= new_ent;
                    else             ent1 <= new_ent;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        ent0 <= new_ent;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= new_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = ent0[DATA_WIDTH-1:0];
    assign head_last = ent0[DATA_WIDTH];
    assign head_vld  = (occ != 2'd0);

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains sync_fifo into framed valid/ready bursts, flushing partial bursts after an idle timeout.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  valid_rd,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int             CW       = ADDR_WIDTH + 1;
    localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  FULL_LEN = CW'(BURST_LEN);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] idle_tmr;
    logic [CW-1:0] issued;
    logic [CW-1:0] len;
    logic          inflight;
    logic          inflight_last;
    logic [1:0]    occ;
    logic [2:0]    pending;
    logic          pop;
    logic          rd_acc;
    logic          start_full;
    logic          start_flush;
    logic          is_last_rd;

    assign pop         = m_valid && m_ready;
    // Words already committed to the skid buffer once this cycle settles.
    assign pending     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign rd_acc      = rd_en && !fifo_empty;
    assign is_last_rd  = (issued == (len - CW'(1)));
    assign start_full  = (fifo_count >= FULL_LEN);
    assign start_flush = !fifo_empty && (idle_tmr == T_LAST);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start_full || start_flush) state_nxt = BURST;
            end
            BURST: begin
                rd_en = !fifo_empty && (pending < 3'd2) && (issued < len);
                if (rd_en && is_last_rd) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && m_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_tmr      <= '0;
            issued        <= '0;
            len           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= rd_acc;
            if (rd_acc) begin
                issued        <= issued + CW'(1);
                inflight_last <= is_last_rd;
            end
            if (state == IDLE) begin
                if (start_full) begin
                    len      <= FULL_LEN;
                    issued   <= '0;
                    idle_tmr <= '0;
                end else if (start_flush) begin
                    len      <= fifo_count;
                    issued   <= '0;
                    idle_tmr <= '0;
                end else if (!fifo_empty) begin
                    idle_tmr <= idle_tmr + TW'(1);
                end else begin
                    idle_tmr <= '0;
                end
            end
        end
    end

    // Stray valid_rd strobes without a read of ours in flight are dropped here.
    fifo_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (valid_rd && inflight),
        .push_data(rd_data),
        .push_last(inflight_last),
        .pop      (pop),
        .head_data(m_data),
        .head_last(m_last),
        .head_vld (m_valid),
        .occ      (occ)
    );

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Downstream drain stage for `sync_fifo`. It watches the FIFO occupancy and issues `rd_en` pulses, then captures `rd_data`/`valid_rd`. It re-emits the words as framed bursts on a valid/ready stream, with `m_last` marking each burst's final word. A partial burst is flushed when the FIFO holds fewer than `BURST_LEN` words for `TIMEOUT` consecutive cycles.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `ADDR_WIDTH`, 4: FIFO address width; `fifo_count` is `ADDR_WIDTH+1` bits.
- `BURST_LEN`, 4: full burst length. Range 1..2^ADDR_WIDTH.
- `TIMEOUT`, 16: idle cycles before a partial flush. Must be ≥1.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_count`  in  ADDR_WIDTH+1  FIFO occupancy.
- `fifo_empty`  in  1  FIFO empty flag.
- `rd_data`  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read.
- `valid_rd`  in  1  FIFO read-data strobe.
- `rd_en`  out  1  read request to the FIFO.
- `m_data`  out  DATA_WIDTH  output word.
- `m_valid`  out  1  output word valid.
- `m_last`  out  1  final word of the current burst.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  high in BURST and DRAIN.

## Operation
- Reset (asynchronous, immediate):
  - state = IDLE; idle timer, issue counter, burst length, in-flight flag and skid buffer cleared.
  - Outputs: `rd_en`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0.
- IDLE:
  - If `fifo_count` ≥ `BURST_LEN`: go to BURST with len=`BURST_LEN`.
  - Else if not `fifo_empty`: the idle timer increments each cycle.
  - When the timer reaches `TIMEOUT-1`, go to BURST with len=`fifo_count` (sampled that cycle).
  - When `fifo_empty`, the timer clears.
  - The timer also clears on every BURST entry.
- BURST:
  - `rd_en` = !`fifo_empty` && (occ + inflight − pop) < 2.
  - occ = skid entries (0..2); inflight = read accepted last cycle; pop = `m_valid && m_ready`.
  - An accepted read is `rd_en && !fifo_empty`. Each one increments issued and tags the word last = (issued == len−1).
  - When issued reaches len, go to DRAIN.
- DRAIN:
  - `rd_en`=0.
  - When the word with last=1 is popped, go to IDLE.
- This block is the FIFO's only reader. Because len ≤ `fifo_count` at decision time, the FIFO cannot run empty mid-burst. If it does anyway, `rd_en` stalls and the block waits.
- On `valid_rd`, `{last tag, rd_data}` is pushed into the 2-entry skid buffer. The head entry drives `m_data`/`m_last`/`m_valid`.
- Output handshake:
  - `m_data`/`m_last` hold stable while `m_valid && !m_ready`.
  - `m_valid` never drops without a pop.
- A `valid_rd` with no matching in-flight read is ignored.

## Timing
- IDLE→BURST decision: 1 cycle. `rd_en` is high in the first BURST cycle.
- Read latency: `rd_en` at cycle N, `rd_data` at N+1, `m_valid` at N+2.
- With `m_ready` held high: 1 word/cycle; a burst of L words finishes L+2 cycles after BURST entry.
- When `m_ready` is low, at most 2 words are held (buffer + in-flight). `rd_en` drops so that neither overflows.
- Minimum gap between bursts is 1 IDLE cycle.
- Reset mid-burst: outputs drop asynchronously. In-flight data is discarded, and the FIFO is reset separately by system.

## Structure
- Shared package `fifo_pkg` holds:
  - state encoding (IDLE=2'd0, BURST=2'd1, DRAIN=2'd2);
  - the skid depth constant (2).
- Sub-module `fifo_skid_buf`: 2-entry buffer with {last, data} entries, push/pop, and occ out.
- Top level holds the FSM, counters and the `rd_en` logic.

## Test plan
- Full burst:
  - Stimulus: FIFO preloaded with 4 words (0x11..0x14), `m_ready`=1.
  - Response: `rd_en` high for 4 cycles; `m_data` 0x11..0x14 on consecutive cycles; `m_last` only on 0x14; `busy` falls after.
- Partial flush:
  - Stimulus: 2 words in FIFO, no writes.
  - Response: after 16 idle cycles, a 2-word burst with `m_last` on word 2.
  - Then write one more word: the timer restarts from 0.
- Backpressure:
  - Stimulus: 8 words; `m_ready` low for cycles 3–7 of the first burst.
  - Response: no more than 2 words outstanding; order preserved; no loss; `m_data` stable while stalled.
- Back-to-back bursts:
  - Stimulus: 8 words with continuous `m_ready`.
  - Response: two bursts of 4 words, each with its own `m_last`, separated by exactly 1 IDLE cycle.
- Async reset mid-burst:
  - Stimulus: assert `rst_n`=0 between clock edges during BURST.
  - Response: `rd_en`/`m_valid`/`busy` go to 0 immediately; after release the block sits in IDLE.
- Empty FIFO:
  - Stimulus: `fifo_empty`=1 for 100 cycles.
  - Response: `rd_en` never asserted; `busy`=0.
